// File: rtl/usr_pkg.sv
// Shared definitions for the usr_param shift register: MODE encodings, FSM states
// and the burst-capable mode predicate. Rotation is enabled by the USR_ROTATE_EN macro.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_HOLD7 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    // Only shift/rotate modes may run as a multi-step burst.
    function automatic logic is_burst_mode(input logic [2:0] mode);
        logic ok;
        case (mode)
            MODE_SHR, MODE_SHL, MODE_ASR: ok = 1'b1;
`ifdef USR_ROTATE_EN
            MODE_ROR, MODE_ROL:           ok = 1'b1;
`endif
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational next-value function of the universal shift register, shared by the
// single-step and burst paths. Rotate modes are active only with USR_ROTATE_EN.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] nxt
);

    // Per-mode next register value.
    always_comb begin
        nxt = data;
        case (mode)
            MODE_HOLD:  nxt = data;
            MODE_SHR:   nxt = {sin_r, data[WIDTH-1:1]};
            MODE_SHL:   nxt = {data[WIDTH-2:0], sin_l};
            MODE_LOAD:  nxt = din;
`ifdef USR_ROTATE_EN
            MODE_ROR:   nxt = {data[0], data[WIDTH-1:1]};
            MODE_ROL:   nxt = {data[WIDTH-2:0], data[WIDTH-1]};
`else
            MODE_ROR:   nxt = data;
            MODE_ROL:   nxt = data;
`endif
            MODE_ASR:   nxt = {data[WIDTH-1], data[WIDTH-1:1]};
            MODE_HOLD7: nxt = data;
            default:    nxt = data;
        endcase
    end

endmodule

// File: rtl/usr_param.sv
// Universal shift register with single-step operation and counted bursts (IDLE/RUN/FIN).
// Optional rotate modes are controlled by the USR_ROTATE_EN macro.
module usr_param
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] DATAIN,
    input  logic             SIN_R,
    input  logic             SIN_L,
    input  logic             START,
    input  logic [CW-1:0]    COUNT,
    output logic [WIDTH-1:0] DATAOUT,
    output logic             SOUT_R,
    output logic             SOUT_L,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state_r, state_s;
    logic [2:0]       mode_r, mode_s;
    logic [CW-1:0]    count_r, count_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [2:0]       step_mode_s;
    logic [WIDTH-1:0] step_s;

    // During a burst the latched mode drives the step function, otherwise the live MODE.
    always_comb begin
        if (state_r == ST_RUN) begin
            step_mode_s = mode_r;
        end else begin
            step_mode_s = MODE;
        end
    end

    usr_step #(.WIDTH(WIDTH)) u_step (
        .mode  (step_mode_s),
        .data  (data_r),
        .din   (DATAIN),
        .sin_r (SIN_R),
        .sin_l (SIN_L),
        .nxt   (step_s)
    );

    // Next-state, next-data and next-flag logic.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        count_s = count_r;
        data_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (START && is_burst_mode(MODE)) begin
                    mode_s  = MODE;
                    count_s = COUNT;
                    if (COUNT == {CW{1'b0}}) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    data_s = step_s;
                end
            end
            ST_RUN: begin
                data_s  = step_s;
                count_s = count_r - CW'(1'b1);
                if (count_r == CW'(1'b1)) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_FIN);
    end

    // State, data and status registers; BUSY/DONE are registered copies of the next state decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            mode_r  <= 3'b000;
            count_r <= {CW{1'b0}};
            data_r  <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            count_r <= count_s;
            data_r  <= data_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign DATAOUT = data_r;
    assign SOUT_R  = data_r[0];
    assign SOUT_L  = data_r[WIDTH-1];
    assign BUSY    = busy_r;
    assign DONE    = done_r;

endmodule

// File: tb/tb_usr_param.sv
// Self-checking bench for usr_param (WIDTH=8): directed cases plus randomized traffic
// against a behavioural model. Follows USR_ROTATE_EN in the same way as the design.
module tb_usr_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] mode = 3'd0;
    logic [7:0] datain = 8'd0;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic [7:0] dataout;
    logic       sout_r, sout_l, busy, done;

    int tests = 0;
    int fails = 0;

`ifdef USR_ROTATE_EN
    bit rot_en = 1'b1;
`else
    bit rot_en = 1'b0;
`endif

    // Behavioural model state
    logic [7:0] m_data = 8'd0;
    logic [2:0] m_mode = 3'd0;
    int         m_left = 0;
    bit         m_fin  = 1'b0;

    usr_param #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .MODE    (mode),
        .DATAIN  (datain),
        .SIN_R   (sin_r),
        .SIN_L   (sin_l),
        .START   (start),
        .COUNT   (count),
        .DATAOUT (dataout),
        .SOUT_R  (sout_r),
        .SOUT_L  (sout_l),
        .BUSY    (busy),
        .DONE    (done)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] ref_step(input logic [2:0] m, input logic [7:0] d,
                                            input logic sr, input logic sl, input logic [7:0] di);
        logic [7:0] r;
        r = d;
        case (m)
            3'd1: r = (d >> 1) | (sr ? 8'h80 : 8'h00);
            3'd2: r = (d << 1) | {7'd0, sl};
            3'd3: r = di;
            3'd4: if (rot_en) r = (d >> 1) | (d << 7);
            3'd5: if (rot_en) r = (d << 1) | (d >> 7);
            3'd6: r = 8'($signed(d) >>> 1);
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic bit burst_ok(input logic [2:0] m);
        return (m == 3'd1) || (m == 3'd2) || (m == 3'd6) || (rot_en && (m == 3'd4 || m == 3'd5));
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_left > 0) begin
            m_data = ref_step(m_mode, m_data, sin_r, sin_l, datain);
            m_left--;
            if (m_left == 0) m_fin = 1'b1;
        end else if (start && burst_ok(mode)) begin
            m_mode = mode;
            m_left = int'(count);
            if (count == 4'd0) m_fin = 1'b1;
        end else begin
            m_data = ref_step(mode, m_data, sin_r, sin_l, datain);
        end
    endtask

    task automatic model_reset();
        m_data = 8'd0;
        m_left = 0;
        m_fin  = 1'b0;
        m_mode = 3'd0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_data"}, dataout, m_data);
        chk({tag, "_soutr"}, {7'd0, sout_r}, {7'd0, m_data[0]});
        chk({tag, "_soutl"}, {7'd0, sout_l}, {7'd0, m_data[7]});
        chk({tag, "_busy"}, {7'd0, busy}, {7'd0, (m_left > 0) || m_fin});
        chk({tag, "_done"}, {7'd0, done}, {7'd0, m_fin});
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_model(tag);
    endtask

    task automatic set_in(input logic [2:0] m, input logic st, input logic [3:0] c);
        mode  = m;
        start = st;
        count = c;
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1;
        check_model("reset");
        #1 reset = 1'b0;

        // Parallel load
        datain = 8'hA5;
        set_in(3'd3, 1'b0, 4'd0);
        step("load");
        chk("load_a5", dataout, 8'hA5);
        chk("load_soutr", {7'd0, sout_r}, 8'd1);
        chk("load_soutl", {7'd0, sout_l}, 8'd1);

        // Serial shifts from zero
        datain = 8'h00; step("clr1");
        set_in(3'd1, 1'b0, 4'd0); sin_r = 1'b1;
        step("shr1"); chk("shr_80", dataout, 8'h80);
        step("shr2"); chk("shr_c0", dataout, 8'hC0);
        set_in(3'd3, 1'b0, 4'd0); step("clr2");
        set_in(3'd2, 1'b0, 4'd0); sin_l = 1'b1; sin_r = 1'b0;
        step("shl1"); chk("shl_01", dataout, 8'h01);
        step("shl2"); chk("shl_03", dataout, 8'h03);
        sin_l = 1'b0;

`ifdef USR_ROTATE_EN
        // Rotate-right burst of 3
        datain = 8'h81; set_in(3'd3, 1'b0, 4'd0); step("ld81");
        set_in(3'd4, 1'b1, 4'd3); step("ror_start");
        chk("ror_busy_rise", {7'd0, busy}, 8'd1);
        chk("ror_hold", dataout, 8'h81);
        set_in(3'd0, 1'b0, 4'd0);
        step("ror1"); chk("ror_c0", dataout, 8'hC0);
        step("ror2"); chk("ror_60", dataout, 8'h60);
        step("ror3"); chk("ror_30", dataout, 8'h30);
        chk("ror_done", {7'd0, done}, 8'd1);
        step("ror_end"); chk("ror_busy_fall", {7'd0, busy}, 8'd0);
        chk("ror_done_fall", {7'd0, done}, 8'd0);
`else
        // Rotate modes disabled: START with MODE 101 is neither a burst nor a change
        datain = 8'h81; set_in(3'd3, 1'b0, 4'd0); step("ld81");
        set_in(3'd5, 1'b1, 4'd4);
        for (int i = 0; i < 4; i++) begin
            step("norot");
            chk("norot_data", dataout, 8'h81);
            chk("norot_busy", {7'd0, busy}, 8'd0);
            chk("norot_done", {7'd0, done}, 8'd0);
        end
`endif

        // ASR bursts with COUNT=0 and COUNT=2
        datain = 8'h90; set_in(3'd3, 1'b0, 4'd0); step("ld90");
        set_in(3'd6, 1'b1, 4'd0); step("asr0_start");
        chk("asr0_hold", dataout, 8'h90);
        chk("asr0_done", {7'd0, done}, 8'd1);
        set_in(3'd0, 1'b0, 4'd0); step("asr0_end");
        chk("asr0_done_fall", {7'd0, done}, 8'd0);
        set_in(3'd6, 1'b1, 4'd2); step("asr2_start");
        set_in(3'd0, 1'b0, 4'd0);
        step("asr2_1"); step("asr2_2");
        chk("asr2_e4", dataout, 8'hE4);
        chk("asr2_done", {7'd0, done}, 8'd1);
        step("asr2_end");

        // START during a burst is ignored; reset mid-burst aborts without DONE
        datain = 8'h3C; set_in(3'd3, 1'b0, 4'd0); step("ld3c");
        set_in(3'd1, 1'b1, 4'd5); step("b5_start");
        set_in(3'd0, 1'b0, 4'd0); step("b5_1");
        datain = 8'hFF; set_in(3'd3, 1'b1, 4'd1); step("b5_ign");
        chk("b5_ign_0f", dataout, 8'h0F);
        chk("b5_ign_busy", {7'd0, busy}, 8'd1);
        set_in(3'd0, 1'b0, 4'd0);
        async_reset("b5_rst");
        chk("b5_rst_data", dataout, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step("b5_after");
            chk("b5_no_done", {7'd0, done}, 8'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            mode   = 3'($urandom_range(0, 7));
            start  = ($urandom_range(0, 3) == 0);
            count  = 4'($urandom_range(0, 15));
            datain = 8'($urandom);
            sin_r  = 1'($urandom);
            sin_l  = 1'($urandom);
            step("rand");
            if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
